// File: rtl/oai21_bist_pkg.sv
// Shared definitions for the oai21 cell self-test controller.
//   bist_state_t : controller FSM states
//   vec_idx_t    : 3-bit vector index, {A1,A2,B} = {idx[2],idx[1],idx[0]}
//   tag_t        : capture-pipeline tag {valid, idx}
//   exp_oai21    : golden ZN for a given vector index
package oai21_bist_pkg;

    localparam int N_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    typedef logic [2:0] vec_idx_t;

    typedef struct packed {
        logic     valid;
        vec_idx_t idx;
    } tag_t;

    function automatic logic exp_oai21(input vec_idx_t idx);
        return ~((idx[2] | idx[1]) & idx[0]);
    endfunction

endpackage

// File: rtl/oai21_bist_ctrl_tag_pipe.sv
// Delay line carrying the tag of each launched vector until its ZN
// response is due for checking.
//   i_clk   : rising-edge clock
//   i_rst   : synchronous active-high clear
//   i_tag   : tag pushed this edge (valid=0 when nothing was launched)
//   o_tag   : tag pushed DEPTH edges ago
module bist_tag_pipe
    import oai21_bist_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/oai21_bist_ctrl.sv
// Built-in self-test controller for one oai21 cell. Sweeps all 8 input
// vectors N_PASSES times, checks ZN CAPTURE_LAT edges after each launch
// and accumulates pass/fail, a per-vector fail map and an error count.
//   CLK, RST        : clock, synchronous active-high reset
//   START           : run request, honoured only in IDLE or DONE
//   BUSY / DONE     : running (RUN or DRAIN) / results valid
//   FAIL, FAIL_VEC  : sticky mismatch flag and per-vector-index fail map
//   ERR_CNT         : saturating mismatch count
//   A1, A2, B       : registered drive to the cell under test
//   ZN              : cell output, sampled on CLK
// Handshake: START is a level request with no acknowledge; a run begins
// on any edge where START=1 and the controller is in IDLE or DONE.
module oai21_bist_ctrl
    import oai21_bist_pkg::*;
#(
    parameter int N_PASSES    = 4,
    parameter int CAPTURE_LAT = 1,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [7:0]       FAIL_VEC,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             A1,
    output logic             A2,
    output logic             B,
    input  logic             ZN
);

    localparam logic [7:0]       LAST_PASS  = 8'(N_PASSES - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(CAPTURE_LAT - 1);
    localparam logic [CNT_W-1:0] ERR_MAX    = '1;

    bist_state_t      r_state;
    vec_idx_t         r_idx;
    logic [7:0]       r_pass;
    logic [2:0]       r_drain_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [7:0]       r_fail_vec;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_a1;
    logic             r_a2;
    logic             r_b;

    tag_t w_tag_in;
    tag_t w_tag_out;
    logic w_mismatch;

    // A tag is pushed exactly on the edges that launch a vector.
    always_comb begin
        w_tag_in = '0;
        if (r_state == ST_RUN) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.idx   = r_idx;
        end
    end

    bist_tag_pipe #(
        .DEPTH (CAPTURE_LAT)
    ) u_tag_pipe (
        .i_clk (CLK),
        .i_rst (RST),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_mismatch = w_tag_out.valid && (ZN != exp_oai21(w_tag_out.idx));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_pass      <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_vec  <= '0;
            r_err_cnt   <= '0;
            r_a1        <= 1'b0;
            r_a2        <= 1'b0;
            r_b         <= 1'b0;
        end else begin
            // Checking runs independently of the launch side; valid tags
            // only exist while in RUN/DRAIN, so the clears below never race it.
            if (w_mismatch) begin
                r_fail                    <= 1'b1;
                r_fail_vec[w_tag_out.idx] <= 1'b1;
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    {r_a1, r_a2, r_b} <= 3'b000;
                    if (START) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_fail     <= 1'b0;
                        r_fail_vec <= '0;
                        r_err_cnt  <= '0;
                        r_idx      <= '0;
                        r_pass     <= '0;
                    end
                end
                ST_RUN: begin
                    {r_a1, r_a2, r_b} <= r_idx;
                    r_idx             <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_pass <= r_pass + 8'd1;
                        if (r_pass == LAST_PASS) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    {r_a1, r_a2, r_b} <= 3'b000;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign FAIL     = r_fail;
    assign FAIL_VEC = r_fail_vec;
    assign ERR_CNT  = r_err_cnt;
    assign A1       = r_a1;
    assign A2       = r_a2;
    assign B        = r_b;

endmodule

// File: tb/tb_oai21_bist_ctrl.sv
// Bench for oai21_bist_ctrl. Three controller instances with different
// pass counts, capture latencies and counter widths, each wired to a cell
// model that can be ideal, stuck-at, one cycle late, or faulty on a chosen
// set of vector indices.
module tb_oai21_bist_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] fail;
    logic [7:0] fvec [3];
    logic [7:0] ecnt0;
    logic [3:0] ecnt1;
    logic [7:0] ecnt2;
    logic [7:0] ecnt [3];
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] b;
    logic [2:0] zn;
    logic [2:0] zd;

    // Cell model controls: 0 = combinational (xor fault mask), 1 = stuck-at-1,
    // 2 = stuck-at-0, 3 = one extra register (xor fault mask).
    logic [1:0] mode  [3];
    logic [7:0] fmask [3];

    int np_k  [3] = '{1, 4, 2};
    int lat_k [3] = '{1, 1, 2};
    int w_k   [3] = '{8, 4, 8};

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    oai21_bist_ctrl #(.N_PASSES(1), .CAPTURE_LAT(1), .CNT_W(8)) u0 (
        .CLK(clk), .RST(rst), .START(start[0]), .BUSY(busy[0]), .DONE(done[0]),
        .FAIL(fail[0]), .FAIL_VEC(fvec[0]), .ERR_CNT(ecnt0),
        .A1(a1[0]), .A2(a2[0]), .B(b[0]), .ZN(zn[0])
    );

    oai21_bist_ctrl #(.N_PASSES(4), .CAPTURE_LAT(1), .CNT_W(4)) u1 (
        .CLK(clk), .RST(rst), .START(start[1]), .BUSY(busy[1]), .DONE(done[1]),
        .FAIL(fail[1]), .FAIL_VEC(fvec[1]), .ERR_CNT(ecnt1),
        .A1(a1[1]), .A2(a2[1]), .B(b[1]), .ZN(zn[1])
    );

    oai21_bist_ctrl #(.N_PASSES(2), .CAPTURE_LAT(2), .CNT_W(8)) u2 (
        .CLK(clk), .RST(rst), .START(start[2]), .BUSY(busy[2]), .DONE(done[2]),
        .FAIL(fail[2]), .FAIL_VEC(fvec[2]), .ERR_CNT(ecnt2),
        .A1(a1[2]), .A2(a2[2]), .B(b[2]), .ZN(zn[2])
    );

    always_comb begin
        ecnt[0] = ecnt0;
        ecnt[1] = {4'b0000, ecnt1};
        ecnt[2] = ecnt2;
    end

    function automatic logic oai(input logic x1, input logic x2, input logic y);
        return ~((x1 | x2) & y);
    endfunction

    always_comb begin
        zn = '0;
        for (int k = 0; k < 3; k++) begin
            case (mode[k])
                2'd1:    zn[k] = 1'b1;
                2'd2:    zn[k] = 1'b0;
                2'd3:    zn[k] = zd[k];
                default: zn[k] = oai(a1[k], a2[k], b[k]) ^ fmask[k][{a1[k], a2[k], b[k]}];
            endcase
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            zd[k] <= oai(a1[k], a2[k], b[k]) ^ fmask[k][{a1[k], a2[k], b[k]}];
        end
    end

    // Vector indices on which a cell stuck at v disagrees with the golden table.
    function automatic logic [7:0] stuck_mask(input logic v);
        logic [7:0] m;
        logic [2:0] t;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            t    = 3'(i);
            m[i] = (oai(t[2], t[1], t[0]) != v);
        end
        return m;
    endfunction

    // Every faulty index fails once per pass; the counter clips at all-ones.
    function automatic int exp_err(input int k, input logic [7:0] m);
        int c;
        int sat;
        c   = $countones(m) * np_k[k];
        sat = (1 << w_k[k]) - 1;
        return (c > sat) ? sat : c;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Start instance k and follow it to DONE. poke>0 re-asserts START for
    // one cycle at that run cycle, which must have no effect.
    task automatic run(input int k, input int poke, input string tag);
        int cyc;
        int busy_c;
        int ea;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        chk({tag, "_busy_at_start"}, busy[k], 1);
        chk({tag, "_fail_cleared"}, fail[k], 0);
        chk({tag, "_fvec_cleared"}, fvec[k], 0);
        chk({tag, "_ecnt_cleared"}, ecnt[k], 0);
        busy_c = busy[k];
        cyc    = 0;
        while (!done[k] && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            start[k] = (cyc == poke);
            busy_c  += busy[k];
            ea = (cyc <= 8 * np_k[k]) ? ((cyc - 1) % 8) : 0;
            chk({tag, "_drive"}, {a1[k], a2[k], b[k]}, ea);
        end
        start[k] = 1'b0;
        chk({tag, "_done"}, done[k], 1);
        chk({tag, "_run_len"}, cyc, 8 * np_k[k] + lat_k[k]);
        chk({tag, "_busy_len"}, busy_c, 8 * np_k[k] + lat_k[k]);
        chk({tag, "_busy_end"}, busy[k], 0);
    endtask

    task automatic results(input int k, input string tag, input logic [7:0] m);
        chk({tag, "_fail"}, fail[k], (m != 8'h00) ? 1 : 0);
        chk({tag, "_fvec"}, fvec[k], m);
        chk({tag, "_ecnt"}, ecnt[k], exp_err(k, m));
    endtask

    initial begin
        logic [7:0] m;
        int         k;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) begin
            mode[i]  = 2'd0;
            fmask[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy[i], 0);
            chk("rst_done", done[i], 0);
            chk("rst_fail", fail[i], 0);
            chk("rst_fvec", fvec[i], 0);
            chk("rst_ecnt", ecnt[i], 0);
            chk("rst_drive", {a1[i], a2[i], b[i]}, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Ideal cell, one pass, latency 1: 9 busy cycles, clean result
        run(0, 0, "ideal");
        chk("ideal_fail", fail[0], 0);
        chk("ideal_fvec", fvec[0], 8'h00);
        chk("ideal_ecnt", ecnt[0], 0);

        // Stuck-at-1, four passes
        mode[1] = 2'd1;
        run(1, 0, "sa1");
        chk("sa1_fail", fail[1], 1);
        chk("sa1_fvec", fvec[1], 8'hA8);
        chk("sa1_ecnt", ecnt[1], 12);

        // Stuck-at-0, 4-bit counter saturates (raw count 20)
        mode[1] = 2'd2;
        run(1, 0, "sa0");
        chk("sa0_fail", fail[1], 1);
        chk("sa0_fvec", fvec[1], 8'h57);
        chk("sa0_ecnt", ecnt[1], 15);

        // Restart from DONE with a healthy cell; clearing is checked in run
        mode[1] = 2'd0;
        run(1, 0, "rerun");
        results(1, "rerun", 8'h00);

        // Cell one cycle late against latency 1: must be flagged
        mode[0] = 2'd3;
        run(0, 0, "late_l1");
        chk("late_l1_fail", fail[0], 1);
        chk("late_l1_ecnt_nz", (ecnt[0] != 0) ? 1 : 0, 1);
        mode[0] = 2'd0;

        // Same late cell against latency 2, START poked mid-run
        mode[2] = 2'd3;
        run(2, 3, "late_l2");
        results(2, "late_l2", 8'h00);

        // Random per-index fault masks on random instances
        for (int it = 0; it < 8; it++) begin
            k        = $urandom_range(0, 2);
            m        = 8'($urandom_range(0, 255));
            mode[k]  = (k == 2) ? 2'd3 : 2'd0;
            fmask[k] = m;
            run(k, $urandom_range(0, 6), "rnd");
            results(k, "rnd", m);
            fmask[k] = 8'h00;
        end

        // Reset in the middle of a stuck-at-1 run
        mode[1] = 2'd1;
        m       = stuck_mask(1'b1) & 8'h0F;
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_fvec_part", fvec[1], m);
        chk("mid_ecnt_part", ecnt[1], $countones(m));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", busy[1], 0);
        chk("mid_rst_done", done[1], 0);
        chk("mid_rst_drive", {a1[1], a2[1], b[1]}, 0);
        chk("mid_rst_ecnt", ecnt[1], 0);
        chk("mid_rst_fail", fail[1], 0);
        chk("mid_rst_fvec", fvec[1], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_stays_idle", busy[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oai21_bist_ctrl.md
Name: oai21_bist_ctrl

Overview:
Built-in self-test controller for one oai21 standard-cell instance. It works from the opposite end of the cell interface: it drives the cell's A1/A2/B inputs and samples and checks its ZN output. It steps through all 8 input combinations for a programmable number of passes. It compares ZN against the expected value ~((A1|A2)&B) and reports pass/fail, a per-vector fail map and an error count. The block sits beside the cell-under-test in the library silicon-characterisation test chip.

Parameters:
N_PASSES, 4, number of full 8-vector sweeps per run (1..255)
CAPTURE_LAT, 1, clock edges from vector launch to ZN sample (1..4)
CNT_W, 8, width of the error counter

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous, active-high reset
START  input  1  run request; sampled only in IDLE or DONE
BUSY  output  1  high in RUN and DRAIN
DONE  output  1  high in DONE; results valid
FAIL  output  1  sticky; any mismatch in the current/last run
FAIL_VEC  output  8  bit i set if vector index i ever mismatched
ERR_CNT  output  CNT_W  total mismatches, saturating
A1  output  1  registered drive to cell A1
A2  output  1  registered drive to cell A2
B  output  1  registered drive to cell B
ZN  input  1  cell-under-test output, sampled on CLK

Behaviour:
- Single clock CLK. Reset is synchronous and active-high (RST). All state updates on the rising edge.
- Reset values: state=IDLE; BUSY, DONE, FAIL, A1, A2, B = 0; FAIL_VEC=0; ERR_CNT=0; all counters and pipeline regs 0. RST has priority over every other input, including mid-run. A mid-run RST aborts with no partial results retained.
- Vector encoding: index idx[2:0] drives {A1,A2,B} = {idx[2],idx[1],idx[0]}. expected(idx) = ~((idx[2]|idx[1]) & idx[0]).
- FSM states and transitions:
  - IDLE: drive outputs 0. START=1 -> RUN. On that edge clear FAIL, FAIL_VEC and ERR_CNT, and set idx=0, pass=0.
  - RUN: each edge launches vector idx on A1/A2/B and pushes {valid=1, idx} into a CAPTURE_LAT-deep tag pipeline. idx increments 0..7 and wraps. pass increments on the 7->0 wrap. After the launch of idx=7 on pass N_PASSES-1 -> DRAIN. Total launches = 8*N_PASSES.
  - DRAIN: A1/A2/B return to 0. Zero-tags (valid=0) are pushed. Stay CAPTURE_LAT cycles -> DONE.
  - DONE: DONE=1, results held. START=1 -> RUN with the same clearing as IDLE. Otherwise stay.
- START is ignored in RUN and DRAIN. START is level-sampled, so holding it high in DONE restarts immediately.
- Check rule: at each edge where the tag pipeline output has valid=1, compare ZN with expected(tag.idx). A vector launched at edge e is checked at edge e+CAPTURE_LAT. On mismatch:
  - set FAIL and FAIL_VEC[tag.idx];
  - ERR_CNT += 1, saturating at 2^CNT_W-1 with no wrap.
- The last check completes on the final DRAIN edge, so FAIL/FAIL_VEC/ERR_CNT are final when DONE first reads 1.
- BUSY = (state==RUN)|(state==DRAIN), registered. Run length from START edge to DONE = 8*N_PASSES + CAPTURE_LAT cycles.
- Simultaneous events: with CAPTURE_LAT=1, a launch and a check happen on the same edge; both proceed. A restart from DONE clears results on the START edge; no stale check can occur because the pipeline is empty in DONE.

Decomposition:
- Shared package oai21_bist_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - vector-index type (3 bits);
  - a function exp_oai21(idx) returning the expected ZN;
  - the constant N_VEC=8.
- One sub-module, bist_tag_pipe: a CAPTURE_LAT-deep shift register of {valid, idx[2:0]} with synchronous clear on RST.

Test Plan:
- Ideal cell model (ZN=~((A1|A2)&B), 1-cycle registered), CAPTURE_LAT=1, N_PASSES=1, START pulse -> BUSY for 9 cycles, then DONE=1, FAIL=0, FAIL_VEC=0x00, ERR_CNT=0.
- ZN stuck-at-1, N_PASSES=4 -> FAIL=1, FAIL_VEC=0xA8 (idx 3,5,7), ERR_CNT=12.
- ZN stuck-at-0, CNT_W=4, N_PASSES=4 -> FAIL_VEC=0x57, ERR_CNT saturates at 15 (raw count 20).
- Cell model delayed 2 cycles, CAPTURE_LAT=1 -> FAIL=1 and ERR_CNT nonzero. Same model with CAPTURE_LAT=2 -> FAIL=0, DONE after 8*N_PASSES+2 cycles.
- RST asserted at cycle 5 of RUN -> next edge: IDLE, BUSY=0, A1/A2/B=0, ERR_CNT=0. START mid-run (no reset) -> ignored; run length unchanged.
- Fault run to DONE, then second START with an ideal model -> FAIL/FAIL_VEC/ERR_CNT cleared on the START edge; final FAIL=0.
